// File: rtl/gpu_pkg.sv
// Shared types, widths and helpers for the block dispatcher.
package gpu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } dispatch_state_t;

  // Number of blocks needed to cover num threads with den threads per block.
  // The sum is one bit wider so that 255 threads do not wrap before dividing.
  function automatic logic [DATA_W-1:0] ceil_div(input logic [DATA_W-1:0] num,
                                                 input int unsigned den);
    logic [DATA_W:0] sum;
    sum = {1'b0, num} + (DATA_W+1)'(den - 32'd1);
    return DATA_W'(sum / (DATA_W+1)'(den));
  endfunction

endpackage

// File: rtl/dispatch_core_slot.sv
// Per-core slot: holds one core's start/reset handshake and its block assignment.
module dispatch_core_slot
  import gpu_pkg::*;
#(
  parameter int TW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              grant,
  input  logic [DATA_W-1:0] block_id_in,
  input  logic [TW-1:0]     threads_in,
  input  logic              core_done,
  output logic              busy,
  output logic              retire,
  output logic              core_start,
  output logic              core_reset,
  output logic [DATA_W-1:0] core_block_id,
  output logic [TW-1:0]     core_thread_count
);

  // A finish only counts while the core actually holds a block; a core still in
  // its reset pulse is not yet free, so a retiring core cannot be regranted at once.
  always_comb begin
    retire = core_start & core_done;
    busy   = core_start | core_reset;
  end

  // Slot registers: launch init pulse, grant, retire pulse, otherwise reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_start        <= 1'b0;
      core_reset        <= 1'b0;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else if (init) begin
      core_start <= 1'b0;
      core_reset <= 1'b1;
    end else if (grant) begin
      core_start        <= 1'b1;
      core_reset        <= 1'b0;
      core_block_id     <= block_id_in;
      core_thread_count <= threads_in;
    end else if (retire) begin
      core_start <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      core_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into blocks and hands them to compute cores one per cycle.
module block_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [DATA_W-1:0]                                thread_count,
  input  logic [NUM_CORES-1:0]                             core_done,
  output logic [NUM_CORES-1:0]                             core_start,
  output logic [NUM_CORES-1:0]                             core_reset,
  output logic [NUM_CORES-1:0][DATA_W-1:0]                 core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0] core_thread_count,
  output logic                                             done
);

  localparam int TW = $clog2(THREADS_PER_BLOCK) + 1;

  dispatch_state_t state_r, next_state_s;

  logic [DATA_W-1:0]    tc_r, total_r, dispatched_r, done_cnt_r;
  logic [DATA_W-1:0]    retire_cnt_s, done_sum_s, base_s;
  logic [NUM_CORES-1:0] busy_s, retire_s, grant_s;
  logic [TW-1:0]        threads_s;
  logic                 init_s, run_s, can_dispatch_s, found_s, last_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; completion uses this cycle's retirements as well.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (start) next_state_s = INIT; else next_state_s = IDLE;
      INIT:    if (total_r == 8'd0) next_state_s = DONE; else next_state_s = RUN;
      RUN:     if (done_sum_s == total_r) next_state_s = DONE; else next_state_s = RUN;
      DONE:    if (!start) next_state_s = IDLE; else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: launch init pulse and the run qualifier.
  always_comb begin
    init_s = 1'b0;
    run_s  = 1'b0;
    case (state_r)
      IDLE:    init_s = start;
      RUN:     run_s  = 1'b1;
      default: begin
        init_s = 1'b0;
        run_s  = 1'b0;
      end
    endcase
  end

  // Completion count including retirements happening this cycle.
  always_comb begin
    retire_cnt_s = 8'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      retire_cnt_s = retire_cnt_s + DATA_W'(retire_s[i]);
    end
    done_sum_s = done_cnt_r + retire_cnt_s;
  end

  // Lowest-index free-slot arbiter and the thread count of the block on offer.
  always_comb begin
    can_dispatch_s = run_s && (dispatched_r < total_r);
    grant_s        = '0;
    found_s        = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (can_dispatch_s && !found_s && !busy_s[i]) begin
        grant_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    last_s = (dispatched_r == total_r - 8'd1);
    base_s = dispatched_r * DATA_W'(THREADS_PER_BLOCK);
    if (last_s) begin
      threads_s = TW'(tc_r - base_s);
    end else begin
      threads_s = TW'(THREADS_PER_BLOCK);
    end
  end

  // Launch latch and block counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      tc_r         <= 8'd0;
      total_r      <= 8'd0;
      dispatched_r <= 8'd0;
      done_cnt_r   <= 8'd0;
    end else if (init_s) begin
      tc_r         <= thread_count;
      total_r      <= ceil_div(thread_count, THREADS_PER_BLOCK);
      dispatched_r <= 8'd0;
      done_cnt_r   <= 8'd0;
    end else if (run_s) begin
      if (|grant_s) begin
        dispatched_r <= dispatched_r + 8'd1;
      end else begin
        dispatched_r <= dispatched_r;
      end
      done_cnt_r <= done_sum_s;
    end else begin
      done_cnt_r <= done_cnt_r;
    end
  end

  // Kernel-complete flag, registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (next_state_s == DONE);
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_core_slot #(.TW(TW)) u_slot (
      .clk               (clk),
      .reset             (reset),
      .init              (init_s),
      .grant             (grant_s[g]),
      .block_id_in       (dispatched_r),
      .threads_in        (threads_s),
      .core_done         (core_done[g] & run_s),
      .busy              (busy_s[g]),
      .retire            (retire_s[g]),
      .core_start        (core_start[g]),
      .core_reset        (core_reset[g]),
      .core_block_id     (core_block_id[g]),
      .core_thread_count (core_thread_count[g])
    );
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed testbench for block_dispatcher with 2 cores and 4 threads per block.
module tb_block_dispatcher;

  localparam int NC = 2;
  localparam int TW = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [7:0]             thread_count;
  logic [NC-1:0]          core_done;
  logic [NC-1:0]          core_start;
  logic [NC-1:0]          core_reset;
  logic [NC-1:0][7:0]     core_block_id;
  logic [NC-1:0][TW-1:0]  core_thread_count;
  logic                   done;

  int n_vec = 0;
  int n_bad = 0;

  block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .done              (done)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n_disp, id_err, thr_err, seen_done;
    logic [7:0] last_id;
    logic [TW-1:0] last_thr;
    logic [NC-1:0] prev, newbits;

    reset = 1'b1; start = 1'b1; thread_count = 8'd8; core_done = 2'b00;
    // Reset held three cycles with start high.
    repeat (3) tick();
    chk("rst_core_start", core_start, 2'b00);
    chk("rst_core_reset", core_reset, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_block_id", core_block_id, 16'h0000);
    chk("rst_thread_cnt", core_thread_count, 6'd0);

    // Launch of 8 threads: 2 full blocks.
    reset = 1'b0;
    tick();
    chk("t8_init_reset", core_reset, 2'b11);
    chk("t8_init_start", core_start, 2'b00);
    tick();
    chk("t8_run_reset", core_reset, 2'b00);
    chk("t8_run_start", core_start, 2'b00);
    tick();
    chk("t8_c0_start", core_start, 2'b01);
    chk("t8_c0_id", core_block_id[0], 8'd0);
    chk("t8_c0_thr", core_thread_count[0], 3'd4);
    tick();
    chk("t8_c1_start", core_start, 2'b11);
    chk("t8_c1_id", core_block_id[1], 8'd1);
    chk("t8_c1_thr", core_thread_count[1], 3'd4);
    core_done = 2'b11;
    tick();
    chk("t8_ret_start", core_start, 2'b00);
    chk("t8_ret_reset", core_reset, 2'b11);
    chk("t8_done", done, 1'b1);
    core_done = 2'b00; start = 1'b0;
    tick();
    chk("t8_done_clr", done, 1'b0);

    // Idle core_done must be ignored in IDLE.
    core_done = 2'b11;
    tick();
    chk("idle_done_start", core_start, 2'b00);
    chk("idle_done_reset", core_reset, 2'b00);
    core_done = 2'b00;

    // Launch of 10 threads: 3 blocks, last one 2 threads.
    thread_count = 8'd10; start = 1'b1;
    repeat (4) tick();
    chk("t10_both", core_start, 2'b11);
    start = 1'b0;
    core_done = 2'b10;
    tick();
    chk("t10_c1_ret", core_start, 2'b01);
    chk("t10_c1_rpulse", core_reset, 2'b10);
    core_done = 2'b00;
    tick();
    chk("t10_c1_wait", core_start, 2'b01);
    tick();
    chk("t10_c1_regrant", core_start, 2'b11);
    chk("t10_b2_id", core_block_id[1], 8'd2);
    chk("t10_b2_thr", core_thread_count[1], 3'd2);
    core_done = 2'b01;
    tick();
    chk("t10_not_done", done, 1'b0);
    chk("t10_c0_ret", core_start, 2'b10);
    core_done = 2'b10;
    tick();
    chk("t10_done", done, 1'b1);
    core_done = 2'b00;
    tick();
    chk("t10_done_clr", done, 1'b0);

    // Zero-thread launch goes straight to DONE.
    thread_count = 8'd0; start = 1'b1;
    tick();
    chk("t0_init_done", done, 1'b0);
    chk("t0_init_reset", core_reset, 2'b11);
    tick();
    chk("t0_done", done, 1'b1);
    chk("t0_no_start", core_start, 2'b00);
    tick();
    chk("t0_hold_done", done, 1'b1);
    chk("t0_hold_start", core_start, 2'b00);
    start = 1'b0;
    tick();
    chk("t0_done_clr", done, 1'b0);

    // Idle done on core1 ignored, then simultaneous finish of both cores.
    thread_count = 8'd8; start = 1'b1;
    repeat (3) tick();
    chk("sim_c0_only", core_start, 2'b01);
    core_done = 2'b10;
    tick();
    chk("sim_idle_ign_s", core_start, 2'b11);
    chk("sim_idle_ign_r", core_reset, 2'b00);
    core_done = 2'b11;
    tick();
    chk("sim_done", done, 1'b1);
    chk("sim_reset", core_reset, 2'b11);
    core_done = 2'b00; start = 1'b0;
    tick();
    chk("sim_done_clr", done, 1'b0);

    // 0x55 threads latched; input changes mid-run must not matter.
    thread_count = 8'h55; start = 1'b1;
    tick();
    thread_count = 8'h77;
    n_disp = 0; id_err = 0; thr_err = 0; seen_done = 0;
    last_id = 8'd0; last_thr = 3'd0; prev = 2'b00;
    for (int cyc = 0; cyc < 400 && seen_done == 0; cyc++) begin
      tick();
      newbits = core_start & ~prev;
      for (int i = 0; i < NC; i++) begin
        if (newbits[i]) begin
          if (core_block_id[i] != 8'(n_disp)) id_err++;
          if (n_disp < 21 && core_thread_count[i] != 3'd4) thr_err++;
          last_id  = core_block_id[i];
          last_thr = core_thread_count[i];
          n_disp++;
        end
      end
      prev = core_start;
      core_done = core_start;
      if (done) seen_done = 1;
    end
    chk("t55_done_seen", seen_done, 1);
    chk("t55_dispatches", n_disp, 22);
    chk("t55_last_id", last_id, 8'd21);
    chk("t55_last_thr", last_thr, 3'd1);
    chk("t55_id_order", id_err, 0);
    chk("t55_full_thr", thr_err, 0);
    core_done = 2'b00; start = 1'b0;
    tick();
    chk("t55_done_clr", done, 1'b0);

    // Reset mid-run aborts everything.
    thread_count = 8'd8; start = 1'b1;
    repeat (3) tick();
    chk("mr_running", core_start, 2'b01);
    reset = 1'b1;
    tick();
    chk("mr_start", core_start, 2'b00);
    chk("mr_reset", core_reset, 2'b00);
    chk("mr_id", core_block_id, 16'h0000);
    chk("mr_thr", core_thread_count, 6'd0);
    chk("mr_done", done, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("mr_idle_start", core_start, 2'b00);
    start = 1'b1;
    tick();
    chk("mr_idle_launch", core_reset, 2'b11);
    reset = 1'b1; start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
